// File: rtl/ddr3_rw_arbiter.sv
// MIG user-interface sequencer: shares the single DDR3 port between the write-FIFO drain and the
// read-FIFO fill, generates burst addresses and swaps ping-pong frame banks on source/display vsync.
module ddr3_rw_arbiter #(
    parameter int ADDR_W    = 28,
    parameter int CNT_W     = 10,
    parameter int ADDR_MIN  = 0,
    parameter int ADDR_MAX  = 786432,
    parameter int BANK_BIT  = 27,
    parameter int ADDR_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic [6:0]        burst_len,
    input  logic              pingpang_en,
    input  logic              read_valid,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [CNT_W-1:0]  wfifo_rcount,
    input  logic [CNT_W-1:0]  rfifo_wcount,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ARB, WRITE, READ} state_t;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam int         AW        = BANK_BIT;  // frame offset width below the bank bit

    state_t           state, state_next;
    logic [2:0]       wr_sync, rd_sync;
    logic             wr_edge, rd_edge;
    logic             wr_pend, rd_pend;
    logic             wr_bank, rd_bank, wr_bank_upd;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [6:0]       beat_cnt, burst_q, eff_len;
    logic [CNT_W-1:0] eff_len_cnt;
    logic             accept, last_beat;

    // Advance one beat; reaching the frame end wraps to the frame start without touching the bank.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        logic [AW:0] n;
        n = {1'b0, a} + (AW+1)'(ADDR_STEP);
        return (n >= (AW+1)'(ADDR_MAX)) ? AW'(ADDR_MIN) : n[AW-1:0];
    endfunction

    assign eff_len     = (burst_len == 7'd0) ? 7'd1 : burst_len;
    assign eff_len_cnt = CNT_W'(eff_len);
    assign wr_edge     = wr_sync[1] & ~wr_sync[2];
    assign rd_edge     = rd_sync[1] & ~rd_sync[2];
    assign wr_bank_upd = (wr_pend && pingpang_en) ? ~wr_bank : wr_bank;
    assign last_beat   = accept && (beat_cnt == burst_q - 7'd1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        accept     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (init_calib_complete) state_next = ARB;
            end
            ARB: begin
                // Read wins the tie: a starved display FIFO is visible on screen.
                if (!init_calib_complete)                             state_next = IDLE;
                else if (read_valid && (rfifo_wcount < eff_len_cnt)) state_next = READ;
                else if (wfifo_rcount >= eff_len_cnt)                 state_next = WRITE;
            end
            WRITE: begin
                accept = app_rdy & app_wdf_rdy;
                if (accept && (last_beat || !init_calib_complete))
                    state_next = init_calib_complete ? ARB : IDLE;
            end
            READ: begin
                accept = app_rdy;
                if (accept && (last_beat || !init_calib_complete))
                    state_next = init_calib_complete ? ARB : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        app_en       = 1'b0;
        app_cmd      = CMD_WRITE;
        app_addr     = '0;
        app_wdf_wren = 1'b0;
        case (state)
            WRITE: begin
                app_en             = 1'b1;
                app_addr[AW-1:0]   = wr_addr;
                app_addr[BANK_BIT] = wr_bank;
                app_wdf_wren       = app_rdy & app_wdf_rdy;
            end
            READ: begin
                app_en             = 1'b1;
                app_cmd            = CMD_READ;
                app_addr[AW-1:0]   = rd_addr;
                app_addr[BANK_BIT] = rd_bank;
            end
            default: ;
        endcase
    end

    assign app_wdf_end = app_wdf_wren;
    assign busy        = (state == WRITE) || (state == READ);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_sync  <= '0;
            rd_sync  <= '0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b1;
            wr_addr  <= AW'(ADDR_MIN);
            rd_addr  <= AW'(ADDR_MIN);
            beat_cnt <= '0;
            burst_q  <= 7'd1;
        end else begin
            state   <= state_next;
            wr_sync <= {wr_sync[1:0], wr_load};
            rd_sync <= {rd_sync[1:0], rd_load};
            // A new edge in the same cycle as the ARB clear stays pending.
            if (state == ARB) begin
                wr_pend <= 1'b0;
                rd_pend <= 1'b0;
            end
            if (wr_edge) wr_pend <= 1'b1;
            if (rd_edge) rd_pend <= 1'b1;
            case (state)
                ARB: begin
                    if (wr_pend) begin
                        wr_addr <= AW'(ADDR_MIN);
                        wr_bank <= wr_bank_upd;
                    end
                    if (rd_pend) begin
                        rd_addr <= AW'(ADDR_MIN);
                        rd_bank <= pingpang_en ? ~wr_bank_upd : wr_bank_upd;
                    end
                    burst_q  <= eff_len;
                    beat_cnt <= '0;
                end
                WRITE: begin
                    if (accept) begin
                        wr_addr  <= addr_inc(wr_addr);
                        beat_cnt <= (state_next == WRITE) ? beat_cnt + 7'd1 : 7'd0;
                    end
                end
                READ: begin
                    if (accept) begin
                        rd_addr  <= addr_inc(rd_addr);
                        beat_cnt <= (state_next == READ) ? beat_cnt + 7'd1 : 7'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
